fifo_rd_pixel_packer: RTL and testbench

- Read-side consumer of the 8-bit camera-byte FIFO in the gesture-recognition datapath.
- Pops bytes whenever the FIFO is non-empty and packs byte pairs into 16-bit RGB565 pixels, high byte first.
- Tags each pixel with frame coordinates and start-of-frame / end-of-line markers.
- Presents pixels on a valid/ready stream to the downstream skin-detection / frame-buffer stage.

---
 rtl/fifo_rd_pixel_packer.sv | 133 +++++++++++++
 tb/tb_fifo_rd_pixel_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_pixel_packer.sv
// ---------------------------------------------------------------------------
// fifo_rd_pixel_packer
//
// Read-side consumer of the 8-bit camera-byte FIFO. Bytes are popped whenever
// the FIFO is non-empty and there is room in a small internal byte queue.
// Byte pairs are packed into 16-bit RGB565 pixels, high byte first, tagged
// with frame coordinates and sof/eol markers, and offered on a valid/ready
// stream to the downstream stage.
//
// Ports:
//   clkr        FIFO read-domain clock (sole clock)
//   rst         synchronous active-high reset (shared with FIFO reset)
//   empty_flag  FIFO empty, high = empty
//   fifo_do     FIFO read data, valid the cycle after re was high
//   re          FIFO read enable
//   pix_ready   downstream accepts pixel
//   pix_valid   pixel available
//   pix_data    RGB565 pixel {first byte, second byte}
//   pix_x       column of pix_data
//   pix_y       line of pix_data
//   sof         high with pixel (0,0)
//   eol         high with pixel x = H_ACTIVE-1
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
// ---------------------------------------------------------------------------
module fifo_rd_pixel_packer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
) (
    input  logic           clkr,
    input  logic           rst,
    input  logic           empty_flag,
    input  logic [7:0]     fifo_do,
    output logic           re,
    input  logic           pix_ready,
    output logic           pix_valid,
    output logic [15:0]    pix_data,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           sof,
    output logic           eol,
    output logic           frame_done
);

    localparam logic [X_W-1:0] LAST_X = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(V_ACTIVE - 1);

    logic           inflight_p0;
    logic [7:0]     byte_q_p1 [4];
    logic [2:0]     occ_p1;
    logic [7:0]     byte_q_nxt [4];
    logic [2:0]     occ_nxt;
    logic           out_free;
    logic           pop_pair;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;

    // Read issue: the pop happening this cycle is deliberately ignored, so
    // occ + inflight never exceeds what the 4-entry queue can absorb.
    always_comb begin
        re       = !rst && !empty_flag && ((occ_p1 + 3'(inflight_p0)) < 3'd3);
        out_free = !pix_valid || pix_ready;
        pop_pair = (occ_p1 >= 3'd2) && out_free;
    end

    // Queue update: pop two from the head first, then append the captured
    // byte behind whatever remains, so push and pop can share a cycle.
    always_comb begin
        byte_q_nxt = byte_q_p1;
        occ_nxt    = occ_p1;
        if (pop_pair) begin
            byte_q_nxt[0] = byte_q_p1[2];
            byte_q_nxt[1] = byte_q_p1[3];
            occ_nxt       = occ_p1 - 3'd2;
        end
        if (inflight_p0) begin
            byte_q_nxt[occ_nxt[1:0]] = fifo_do;
            occ_nxt                  = occ_nxt + 3'd1;
        end
    end

    // ---- stage p0 -> p1: FIFO read return captured into the byte queue ----
    always_ff @(posedge clkr) begin
        if (rst) begin
            inflight_p0 <= 1'b0;
            occ_p1      <= 3'd0;
        end else begin
            inflight_p0 <= re;
            occ_p1      <= occ_nxt;
        end
    end

    // Queue contents are qualified by occ_p1, so they need no reset.
    always_ff @(posedge clkr) begin
        byte_q_p1 <= byte_q_nxt;
    end

    // ---- stage p1 -> p2: pixel output register and frame counters ----
    always_ff @(posedge clkr) begin
        if (rst) begin
            pix_valid  <= 1'b0;
            pix_data   <= 16'd0;
            pix_x      <= '0;
            pix_y      <= '0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            frame_done <= 1'b0;
            x_cnt      <= '0;
            y_cnt      <= '0;
        end else begin
            frame_done <= pix_valid && pix_ready && (pix_x == LAST_X) && (pix_y == LAST_Y);
            if (pop_pair) begin
                pix_valid <= 1'b1;
                pix_data  <= {byte_q_p1[0], byte_q_p1[1]};
                pix_x     <= x_cnt;
                pix_y     <= y_cnt;
                sof       <= (x_cnt == '0) && (y_cnt == '0);
                eol       <= (x_cnt == LAST_X);
                // Coordinates advance on load, not on acceptance.
                if (x_cnt == LAST_X) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == LAST_Y) ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_pixel_packer.sv
module tb_fifo_rd_pixel_packer;

    localparam int H = 4;
    localparam int V = 2;

    logic        clkr = 1'b0;
    logic        rst = 1'b1;
    logic        empty_flag;
    logic [7:0]  fifo_do = 8'd0;
    logic        re;
    logic        pix_ready = 1'b0;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        sof, eol, frame_done;

    fifo_rd_pixel_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(11), .Y_W(10)) dut (
        .clkr(clkr), .rst(rst), .empty_flag(empty_flag), .fifo_do(fifo_do),
        .re(re), .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .sof(sof), .eol(eol), .frame_done(frame_done)
    );

    always #5 clkr = ~clkr;

    // FIFO model: byte store written by the stimulus, read pointer owned here.
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    logic hold_empty = 1'b0;
    assign empty_flag = hold_empty || (rd_ptr == wr_ptr);

    always @(posedge clkr) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (re) begin
            fifo_do <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Output monitor (samples on the falling edge).
    typedef struct { logic [15:0] d; int x; int y; bit sof; bit eol; } pix_t;
    pix_t cap [0:255];
    int cap_n = 0, fd_cnt = 0, fd_err = 0, stab_err = 0, re_viol = 0;
    bit exp_fd = 0, prev_stall = 0;
    logic [15:0] prev_d; logic [10:0] prev_x; logic [9:0] prev_y; logic prev_s, prev_e;

    always @(negedge clkr) begin
        if (rst) begin
            exp_fd = 0;
            prev_stall = 0;
        end else begin
            if (frame_done !== exp_fd) fd_err++;
            if (frame_done) fd_cnt++;
            if (prev_stall && (!pix_valid || pix_data !== prev_d || pix_x !== prev_x ||
                               pix_y !== prev_y || sof !== prev_s || eol !== prev_e)) stab_err++;
            if (re && empty_flag) re_viol++;
            exp_fd = pix_valid && pix_ready && (pix_x == H-1) && (pix_y == V-1);
            if (pix_valid && pix_ready && cap_n < 256) begin
                cap[cap_n].d = pix_data;
                cap[cap_n].x = int'(pix_x);
                cap[cap_n].y = int'(pix_y);
                cap[cap_n].sof = sof;
                cap[cap_n].eol = eol;
                cap_n++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_d = pix_data; prev_x = pix_x; prev_y = pix_y; prev_s = sof; prev_e = eol;
        end
    end

    int checks = 0, failures = 0;
    int base_cap = 0, base_fd = 0, s = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic [15:0] d, input int x, input int y,
                                         input bit so, input bit eo);
        return {14'd0, d, x[15:0], y[15:0], so, eo};
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic reset_dut();
        @(posedge clkr); #1;
        rst = 1'b1;
        @(posedge clkr); #1;
        @(posedge clkr); #1;
        rst = 1'b0;
        base_cap = cap_n;
        base_fd = fd_cnt;
        s = wr_ptr;
    endtask

    task automatic wait_pixels(input string tag, input int n);
        for (int i = 0; i < 4000 && (cap_n - base_cap) < n; i++) @(posedge clkr);
        #1;
        chk({tag, "_arrived"}, 64'((cap_n - base_cap) >= n), 64'd1);
    endtask

    task automatic check_outputs_reset(input string tag);
        chk({tag, "_re"}, re, 0);
        chk({tag, "_outs"}, {pix_valid, pix_data, pix_x, pix_y, sof, eol, frame_done}, 0);
    endtask

    // Reference: pixel k after reset is bytes k*2,k*2+1 written since reset,
    // coordinates from k in raster order.
    task automatic check_stream(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            pix_t p;
            p = cap[base_cap + k];
            chk($sformatf("%s_pix%0d", tag, k),
                pack(p.d, p.x, p.y, p.sof, p.eol),
                pack({mem[s + 2*k], mem[s + 2*k + 1]}, k % H, (k / H) % V,
                     (k % (H*V)) == 0, (k % H) == H-1));
        end
    endtask

    typedef struct { logic [7:0] b0; logic [7:0] b1; logic [15:0] d; int x; int y; bit so; bit eo; } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{8'hA0, 8'h01, 16'hA001, 0, 0, 1, 0};
        tbl[1] = '{8'hB1, 8'h12, 16'hB112, 1, 0, 0, 0};
        tbl[2] = '{8'hC2, 8'h23, 16'hC223, 2, 0, 0, 0};
        tbl[3] = '{8'hD3, 8'h34, 16'hD334, 3, 0, 0, 1};
        tbl[4] = '{8'hE4, 8'h45, 16'hE445, 0, 1, 0, 0};
        tbl[5] = '{8'hF5, 8'h56, 16'hF556, 1, 1, 0, 0};
        tbl[6] = '{8'h06, 8'h67, 16'h0667, 2, 1, 0, 0};
        tbl[7] = '{8'h17, 8'h78, 16'h1778, 3, 1, 0, 1};

        // Reset state and first two pixels
        reset_dut();
        @(negedge clkr);
        check_outputs_reset("reset");
        @(posedge clkr); #1;
        pix_ready = 1'b1;
        push(8'h12); push(8'h34); push(8'h56); push(8'h78);
        wait_pixels("basic", 2);
        chk("basic_p0", pack(cap[base_cap].d, cap[base_cap].x, cap[base_cap].y, cap[base_cap].sof, cap[base_cap].eol),
            pack(16'h1234, 0, 0, 1, 0));
        chk("basic_p1", pack(cap[base_cap+1].d, cap[base_cap+1].x, cap[base_cap+1].y, cap[base_cap+1].sof, cap[base_cap+1].eol),
            pack(16'h5678, 1, 0, 0, 0));
        chk("basic_re_viol", re_viol, 0);

        // Full small frame from the vector table, then wrap to (0,0)
        reset_dut();
        pix_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin push(tbl[i].b0); push(tbl[i].b1); end
        wait_pixels("frame", 8);
        repeat (3) @(posedge clkr);
        #1;
        for (int i = 0; i < 8; i++) begin
            pix_t p;
            p = cap[base_cap + i];
            chk($sformatf("tbl_%0d", i), pack(p.d, p.x, p.y, p.sof, p.eol),
                pack(tbl[i].d, tbl[i].x, tbl[i].y, tbl[i].so, tbl[i].eo));
        end
        chk("frame_done_cnt", fd_cnt - base_fd, 1);
        chk("frame_done_timing", fd_err, 0);
        push(8'h9A); push(8'hBC);
        wait_pixels("wrap", 9);
        chk("wrap_pix", pack(cap[base_cap+8].d, cap[base_cap+8].x, cap[base_cap+8].y, cap[base_cap+8].sof, cap[base_cap+8].eol),
            pack(16'h9ABC, 0, 0, 1, 0));

        // Backpressure
        reset_dut();
        pix_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
        repeat (20) @(posedge clkr);
        @(negedge clkr);
        chk("bp_valid", pix_valid, 1);
        chk("bp_data", pix_data, 16'h4041);
        chk("bp_re_low", re, 0);
        chk("bp_bytes_read", rd_ptr - s, 5);
        chk("bp_stable", stab_err, 0);
        @(posedge clkr); #1;
        pix_ready = 1'b1;
        wait_pixels("bp", 5);
        check_stream("bp", 5);

        // Odd byte waits for its partner
        reset_dut();
        pix_ready = 1'b1;
        push(8'hAB);
        repeat (10) @(posedge clkr);
        @(negedge clkr);
        chk("odd_no_pix", cap_n - base_cap, 0);
        @(posedge clkr); #1;
        push(8'hCD);
        wait_pixels("odd", 1);
        repeat (5) @(posedge clkr);
        #1;
        chk("odd_count", cap_n - base_cap, 1);
        chk("odd_data", cap[base_cap].d, 16'hABCD);

        // Reset pulse with a read in flight
        reset_dut();
        pix_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        @(posedge clkr); #1;
        rst = 1'b1;
        @(posedge clkr); #1;
        rst = 1'b0;
        base_cap = cap_n; base_fd = fd_cnt; s = wr_ptr;
        @(negedge clkr);
        check_outputs_reset("rstmid");
        @(posedge clkr); #1;
        push(8'hA1); push(8'hA2);
        wait_pixels("rstmid", 1);
        check_stream("rstmid", 1);

        // Randomized empty_flag / pix_ready over three frames
        reset_dut();
        begin
            int pushed;
            pushed = 0;
            for (int c = 0; c < 5000 && (cap_n - base_cap) < 24; c++) begin
                @(posedge clkr); #1;
                pix_ready  = ($urandom_range(0, 3) != 0);
                hold_empty = ($urandom_range(0, 3) == 0);
                if (pushed < 48 && $urandom_range(0, 1) == 1) begin
                    push(8'($urandom));
                    pushed++;
                end
            end
            while (pushed < 48) begin push(8'($urandom)); pushed++; end
        end
        hold_empty = 1'b0;
        pix_ready = 1'b1;
        wait_pixels("rand", 24);
        repeat (3) @(posedge clkr);
        #1;
        check_stream("rand", 24);
        chk("rand_frames", fd_cnt - base_fd, 3);
        chk("rand_fd_timing", fd_err, 0);
        chk("rand_stable", stab_err, 0);
        chk("rand_re_viol", re_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
